// File: rtl/myproject_mul_share_arb_pkg.sv
// Shared constants for the time-shared signed multiplier block.
// Default widths, tag width and op-count width used by the arbiter and multiplier.
package myproject_mul_share_arb_pkg;

   localparam int N_REQ_DEF = 4;
   localparam int A_W_DEF   = 18;
   localparam int B_W_DEF   = 15;
   localparam int P_W_DEF   = 33;
   localparam int TAG_W     = $clog2(N_REQ_DEF);
   localparam int OPC_W     = 16;

   typedef logic [OPC_W-1:0] opcnt_t;

   // Tag width that stays legal when only one requester exists.
   function automatic int tag_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/myproject_mul_18s_15s_33.sv
// Existing combinational multiplier core: 18-bit signed x 15-bit signed -> 33-bit signed.
module myproject_mul_18s_15s_33 (
   input  logic signed [17:0] din0,
   input  logic signed [14:0] din1,
   output logic signed [32:0] dout
);

   logic signed [32:0] a_ext_s;
   logic signed [32:0] b_ext_s;

   assign a_ext_s = {{15{din0[17]}}, din0};
   assign b_ext_s = {{18{din1[14]}}, din1};
   assign dout    = a_ext_s * b_ext_s;

endmodule

// File: rtl/myproject_rr_arb.sv
// Round-robin selector: scans req starting at ptr and returns a one-hot grant.
module myproject_rr_arb #(
   parameter int N_REQ = 4,
   parameter int TW    = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [TW-1:0]    ptr,
   output logic [N_REQ-1:0] grant
);

   logic [TW-1:0] idx_s;
   logic          found_s;

   // First requesting index at or after ptr wins.
   always_comb begin
      grant   = '0;
      found_s = 1'b0;
      idx_s   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx_s        = TW'((int'(ptr) + k) % N_REQ);
         grant[idx_s] = req[idx_s] & ~found_s;
         found_s      = found_s | req[idx_s];
      end
   end

endmodule

// File: rtl/myproject_mul_share_arb.sv
// N_REQ requesters share one signed multiplier through a round-robin arbiter;
// each requester owns one held result register (accept -> rsp_valid in 2 cycles).
module myproject_mul_share_arb
   import myproject_mul_share_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int A_W   = A_W_DEF,
   parameter int B_W   = B_W_DEF,
   parameter int P_W   = P_W_DEF
) (
   input  logic                 ap_clk,
   input  logic                 ap_rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [N_REQ*A_W-1:0] req_a,
   input  logic [N_REQ*B_W-1:0] req_b,
   output logic [N_REQ-1:0]     rsp_valid,
   input  logic [N_REQ-1:0]     rsp_ready,
   output logic [N_REQ*P_W-1:0] rsp_p,
   output logic                 busy,
   output logic [OPC_W-1:0]     op_cnt
);

   localparam int            TW       = tag_width(N_REQ);
   localparam logic [TW-1:0] LAST_TAG = TW'(N_REQ - 1);

   logic [TW-1:0]        ptr_r;
   logic [N_REQ-1:0]     elig_s;
   logic [N_REQ-1:0]     grant_s;
   logic                 accept_s;
   logic [TW-1:0]        tag_s;
   logic [A_W-1:0]       a_sel_s;
   logic [B_W-1:0]       b_sel_s;
   logic                 s1_vld_r;
   logic [TW-1:0]        s1_tag_r;
   logic signed [A_W-1:0] s1_a_r;
   logic signed [B_W-1:0] s1_b_r;
   logic signed [P_W-1:0] prod_s;
   logic [N_REQ-1:0]     rsp_vld_r;
   logic [P_W-1:0]       rsp_p_r [N_REQ];
   opcnt_t               op_cnt_r;

   // Eligibility: valid, nothing in flight for this requester, no result held; nobody while in reset.
   always_comb begin
      elig_s = '0;
      for (int i = 0; i < N_REQ; i++) begin
         elig_s[i] = ap_rst_n & req_valid[i] & ~rsp_vld_r[i]
                   & ~(s1_vld_r & (s1_tag_r == TW'(i)));
      end
   end

   myproject_rr_arb #(
      .N_REQ (N_REQ),
      .TW    (TW)
   ) u_rr_arb (
      .req   (elig_s),
      .ptr   (ptr_r),
      .grant (grant_s)
   );

   assign req_ready = grant_s;
   assign accept_s  = |grant_s;

   // One-hot operand and tag mux driven by the grant.
   always_comb begin
      a_sel_s = '0;
      b_sel_s = '0;
      tag_s   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         a_sel_s = a_sel_s | ({A_W{grant_s[i]}} & req_a[i*A_W +: A_W]);
         b_sel_s = b_sel_s | ({B_W{grant_s[i]}} & req_b[i*B_W +: B_W]);
         tag_s   = tag_s | (grant_s[i] ? TW'(i) : TW'(0));
      end
   end

   // Multiplier input stage, round-robin pointer and accepted-op counter.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         s1_vld_r <= 1'b0;
         s1_tag_r <= '0;
         s1_a_r   <= '0;
         s1_b_r   <= '0;
         ptr_r    <= '0;
         op_cnt_r <= '0;
      end else begin
         s1_vld_r <= accept_s;
         if (accept_s) begin
            s1_tag_r <= tag_s;
            s1_a_r   <= a_sel_s;
            s1_b_r   <= b_sel_s;
            ptr_r    <= (tag_s == LAST_TAG) ? TW'(0) : tag_s + TW'(1);
            op_cnt_r <= op_cnt_r + OPC_W'(1);
         end
      end
   end

   myproject_mul_18s_15s_33 u_mul (
      .din0 (s1_a_r),
      .din1 (s1_b_r),
      .dout (prod_s)
   );

   // Per-requester result registers: capture on stage exit, hold until drained.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         rsp_vld_r <= '0;
         for (int i = 0; i < N_REQ; i++) begin
            rsp_p_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (s1_vld_r && (s1_tag_r == TW'(i))) begin
               rsp_p_r[i]   <= prod_s;
               rsp_vld_r[i] <= 1'b1;
            end else if (rsp_ready[i]) begin
               rsp_vld_r[i] <= 1'b0;
            end
         end
      end
   end

   // Pack held results onto the flat output bus.
   always_comb begin
      rsp_p = '0;
      for (int i = 0; i < N_REQ; i++) begin
         rsp_p[i*P_W +: P_W] = rsp_p_r[i];
      end
   end

   assign rsp_valid = rsp_vld_r;
   assign busy      = s1_vld_r | (|rsp_vld_r);
   assign op_cnt    = op_cnt_r;

endmodule

// File: tb/tb_myproject_mul_share_arb.sv
// Directed bench for the shared multiplier arbiter: reset, products, round-robin
// order, backpressure, mid-operation reset and op counter wrap.
module tb_myproject_mul_share_arb;

   logic         ap_clk;
   logic         ap_rst_n;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [71:0]  req_a;
   logic [59:0]  req_b;
   logic [3:0]   rsp_valid;
   logic [3:0]   rsp_ready;
   logic [131:0] rsp_p;
   logic         busy;
   logic [15:0]  op_cnt;

   int checks;
   int errors;
   logic [32:0] exp_p [4];
   int seq4 [15];

   myproject_mul_share_arb dut (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_p     (rsp_p),
      .busy      (busy),
      .op_cnt    (op_cnt)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input int r, input logic [17:0] a, input logic [14:0] b);
      req_a[r*18 +: 18] = a;
      req_b[r*15 +: 15] = b;
   endtask

   function automatic logic [32:0] get_p(input int r);
      return rsp_p[r*33 +: 33];
   endfunction

   task automatic tick();
      @(posedge ap_clk);
      #2;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      ap_rst_n  = 1'b0;
      req_valid = 4'h0;
      rsp_ready = 4'hF;
      req_a     = 72'd0;
      req_b     = 60'd0;
      exp_p[0]  = 33'h0_0000_02BC;
      exp_p[1]  = 33'h1_FFFF_F830;
      exp_p[2]  = 33'h0_7FFD_C001;
      exp_p[3]  = 33'h0_0000_0001;
      seq4      = '{3, 0, 1, 2, 3, 0, 1, 3, 0, 1, 3, 0, 1, 3, 0};

      // Reset values, with requests present
      req_valid = 4'hF;
      repeat (2) @(posedge ap_clk);
      #2;
      chk("rst_ready", 64'(req_ready), 64'h0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_op_cnt", 64'(op_cnt), 64'h0);
      chk("rst_rsp_p", 64'(|rsp_p), 64'h0);
      req_valid = 4'h0;
      ap_rst_n  = 1'b1;
      tick();

      // Single request 3 * -5
      set_op(0, 18'h00003, 15'h7FFB);
      req_valid = 4'b0001;
      #1;
      chk("single_ready", 64'(req_ready), 64'h1);
      tick();
      req_valid = 4'h0;
      chk("single_lat1_valid", 64'(rsp_valid), 64'h0);
      chk("single_busy", 64'(busy), 64'h1);
      chk("single_op_cnt", 64'(op_cnt), 64'h1);
      tick();
      chk("single_valid", 64'(rsp_valid), 64'h1);
      chk("single_p", 64'(get_p(0)), 64'h1_FFFF_FFF1);
      tick();
      chk("single_drained", 64'(rsp_valid), 64'h0);
      chk("single_idle", 64'(busy), 64'h0);

      // Extremes: -2^17 * -2^14 on requester 1, held under backpressure
      rsp_ready = 4'h0;
      set_op(1, 18'h20000, 15'h4000);
      req_valid = 4'b0010;
      #1;
      chk("ext1_ready", 64'(req_ready), 64'h2);
      tick();
      req_valid = 4'h0;
      tick();
      chk("ext1_valid", 64'(rsp_valid), 64'h2);
      chk("ext1_p", 64'(get_p(1)), 64'h0_8000_0000);
      tick();
      chk("ext1_hold_valid", 64'(rsp_valid), 64'h2);
      chk("ext1_hold_p", 64'(get_p(1)), 64'h0_8000_0000);
      rsp_ready = 4'hF;
      tick();
      chk("ext1_drained", 64'(rsp_valid), 64'h0);

      // Extremes: (2^17-1) * -2^14 on requester 2
      set_op(2, 18'h1FFFF, 15'h4000);
      req_valid = 4'b0100;
      #1;
      chk("ext2_ready", 64'(req_ready), 64'h4);
      tick();
      req_valid = 4'h0;
      tick();
      chk("ext2_valid", 64'(rsp_valid), 64'h4);
      chk("ext2_p", 64'(get_p(2)), 64'h1_8000_4000);
      tick();

      // All four continuously valid: one accept per cycle, rotating from ptr=3
      set_op(0, 18'd100, 15'd7);
      set_op(1, 18'h3FFFE, 15'd1000);
      set_op(2, 18'h1FFFF, 15'h3FFF);
      set_op(3, 18'h3FFFF, 15'h7FFF);
      req_valid = 4'hF;
      #1;
      for (int k = 0; k < 8; k++) begin
         chk("rr_ready", 64'(req_ready), 64'(4'b0001 << ((3 + k) % 4)));
         chk("rr_op_cnt", 64'(op_cnt), 64'(3 + k));
         if (k >= 2) begin
            chk("rr_rsp_valid", 64'(rsp_valid), 64'(4'b0001 << ((1 + k) % 4)));
            chk("rr_rsp_p", 64'(get_p((1 + k) % 4)), 64'(exp_p[(1 + k) % 4]));
         end
         tick();
      end
      req_valid = 4'h0;
      repeat (3) tick();
      chk("rr_idle", 64'(busy), 64'h0);
      chk("rr_op_cnt_end", 64'(op_cnt), 64'd11);

      // Backpressure on requester 2: its result holds, others keep rotating
      rsp_ready = 4'b1011;
      req_valid = 4'hF;
      #1;
      for (int k = 0; k < 15; k++) begin
         chk("bp_ready", 64'(req_ready), 64'(4'b0001 << seq4[k]));
         chk("bp_op_cnt", 64'(op_cnt), 64'(11 + k));
         if (k >= 5) begin
            chk("bp_hold_valid", 64'(rsp_valid[2]), 64'h1);
            chk("bp_hold_p", 64'(get_p(2)), 64'(exp_p[2]));
         end
         tick();
      end
      rsp_ready = 4'hF;
      req_valid = 4'h0;
      repeat (4) tick();
      chk("bp_idle", 64'(busy), 64'h0);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("bp_op_cnt", 64'(op_cnt), 64'd26);

      // Reset between accept and result
      set_op(0, 18'd9, 15'd9);
      req_valid = 4'b0001;
      #1;
      chk("mrst_ready", 64'(req_ready), 64'h1);
      tick();
      req_valid = 4'hF;
      ap_rst_n  = 1'b0;
      #1;
      chk("mrst_ready_low", 64'(req_ready), 64'h0);
      chk("mrst_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("mrst_busy", 64'(busy), 64'h0);
      chk("mrst_op_cnt", 64'(op_cnt), 64'h0);
      chk("mrst_rsp_p", 64'(|rsp_p), 64'h0);
      tick();
      req_valid = 4'h0;
      ap_rst_n  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("mrst_no_stray", 64'(rsp_valid), 64'h0);
      end
      chk("mrst_op_cnt_after", 64'(op_cnt), 64'h0);
      chk("mrst_idle", 64'(busy), 64'h0);

      // Counter wrap after 65536 accepts
      req_valid = 4'hF;
      repeat (65535) @(posedge ap_clk);
      #2;
      chk("wrap_ffff", 64'(op_cnt), 64'hFFFF);
      tick();
      req_valid = 4'h0;
      chk("wrap_zero", 64'(op_cnt), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
